// File: rtl/usb_tx_line_encoder.sv
// rtl/usb_tx_line_encoder.sv - USB transmit back end: bit stuffing, NRZI encoding, DP/DM drive and EOP
module usb_tx_line_encoder #(
  parameter int STUFF_LIMIT    = 6,
  parameter int EOP_SE0_CYCLES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic crc_sending,
  input  logic in_bit,
  output logic stuff_pause,
  output logic DP_out,
  output logic DM_out,
  output logic tx_active,
  output logic tx_done
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int EW = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES) : 1;
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] EOP_LAST = EW'(EOP_SE0_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, EOP_SE0, EOP_J} state_e;

  state_e          state_q, state_d;
  logic            level_q, level_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [EW-1:0]   eop_q, eop_d;
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            enc_level;

  // NRZI: a 0 toggles the line level, a 1 holds it
  assign enc_level   = in_bit ? level_q : ~level_q;
  assign stuff_pause = (state_q == SEND) && (ones_q == ONES_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      level_q  <= 1'b1;
      ones_q   <= '0;
      eop_q    <= '0;
      dp_q     <= 1'b1;
      dm_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ones_q   <= ones_d;
      eop_q    <= eop_d;
      dp_q     <= dp_d;
      dm_q     <= dm_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    ones_d   = ones_q;
    eop_d    = eop_q;
    dp_d     = dp_q;
    dm_d     = dm_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        level_d  = 1'b1;
        dp_d     = 1'b1;
        dm_d     = 1'b0;
        active_d = 1'b0;
        if (crc_sending) begin
          level_d  = enc_level;
          ones_d   = in_bit ? OW'(1) : '0;
          dp_d     = enc_level;
          dm_d     = ~enc_level;
          active_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        active_d = 1'b1;
        // A pending stuff bit wins over end of packet so it is never lost
        if (stuff_pause) begin
          level_d = ~level_q;
          ones_d  = '0;
          dp_d    = ~level_q;
          dm_d    = level_q;
        end else if (crc_sending) begin
          level_d = enc_level;
          ones_d  = in_bit ? ones_q + OW'(1) : '0;
          dp_d    = enc_level;
          dm_d    = ~enc_level;
        end else begin
          eop_d   = '0;
          dp_d    = 1'b0;
          dm_d    = 1'b0;
          state_d = EOP_SE0;
        end
      end
      EOP_SE0: begin
        if (eop_q == EOP_LAST) begin
          level_d = 1'b1;
          ones_d  = '0;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
          done_d  = 1'b1;
          state_d = EOP_J;
        end else begin
          eop_d = eop_q + EW'(1);
        end
      end
      EOP_J: begin
        active_d = 1'b0;
        dp_d     = 1'b1;
        dm_d     = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DP_out    = dp_q;
  assign DM_out    = dm_q;
  assign tx_active = active_q;
  assign tx_done   = done_q;

endmodule
